// File: rtl/atm_cell_pkg.sv
// atm_cell_pkg: UNI cell layout, collector state encoding and the HEC helper
// shared by the Utopia Rx collector and its cell buffer.
package atm_cell_pkg;

    localparam int         CELL_BYTES = 53;
    localparam logic [7:0] HEC_COSET  = 8'h55;
    localparam int         NUM_RX     = 4;
    localparam int         PORT_W     = $clog2(NUM_RX);

    // byte0 lands in the MSBs, so the 424-bit shift buffer casts straight to this
    typedef struct packed {
        logic [3:0]       gfc;
        logic [7:0]       vpi;
        logic [15:0]      vci;
        logic [2:0]       pt;
        logic             clp;
        logic [7:0]       hec;
        logic [0:47][7:0] payload;
    } uni_cell_t;

    typedef enum logic [1:0] {IDLE, HUNT, RECV, CHECK} rx_state_e;

    function automatic logic [7:0] hec_calc(input logic [31:0] hdr);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 31; i >= 0; i--) c = {c[6:0], 1'b0} ^ ((c[7] ^ hdr[i]) ? 8'h07 : 8'h00);
        return c ^ HEC_COSET;
    endfunction

endpackage

// File: rtl/cell_fifo.sv
// cell_fifo: cell buffer with a registered show-ahead output stage; full counts
// the output register too, so DEPTH is the total number of cells held.
module cell_fifo
    import atm_cell_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      push_i,
    input  uni_cell_t data_i,
    input  logic      ready_i,
    output logic      valid_o,
    output uni_cell_t data_o,
    output logic      full_o
);

    localparam int AW = $clog2(DEPTH);

    uni_cell_t     mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q;
    logic          valid_q, load;
    uni_cell_t     data_q;

    assign load    = (cnt_q != '0) && (!valid_q || ready_i);
    assign full_o  = (cnt_q + (AW+1)'(valid_q)) == (AW+1)'(DEPTH);
    assign valid_o = valid_q;
    assign data_o  = data_q;

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wp_q] <= data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            if (push_i) wp_q <= wp_q + AW'(1);
            if (load) begin
                data_q  <= mem_q[rp_q];
                rp_q    <= rp_q + AW'(1);
                valid_q <= 1'b1;
            end else if (ready_i) begin
                valid_q <= 1'b0;
            end
            cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(load);
        end
    end

endmodule

// File: rtl/utopia_rx_collector.sv
// utopia_rx_collector: Utopia L1 Rx handshake and 53-byte cell assembly into a cell FIFO.
// Define ATM_HEC_CHECK_EN to drop cells whose header HEC does not match.
module utopia_rx_collector
    import atm_cell_pkg::*;
#(
    parameter int PORT_ID    = 0,
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rx_clav_i,
    input  logic              rx_soc_i,
    input  logic [7:0]        rx_data_i,
    output logic              rx_en_n_o,
    output logic              cell_valid_o,
    input  logic              cell_ready_i,
    output uni_cell_t         cell_data_o,
    output logic [PORT_W-1:0] cell_port_o,
    output logic [CNT_W-1:0]  cell_cnt_o,
    output logic [CNT_W-1:0]  runt_cnt_o,
    output logic [CNT_W-1:0]  hec_err_cnt_o
);

    localparam int         CW   = 8 * CELL_BYTES;
    localparam logic [5:0] LAST = 6'(CELL_BYTES - 1);

    rx_state_e      state_q;
    logic           rx_en_n_q, fifo_full, push, hec_ok;
    logic [5:0]     idx_q;
    logic [CW-1:0]  buf_q;
    logic [CNT_W-1:0] cell_cnt_q, runt_q;

`ifdef ATM_HEC_CHECK_EN
    logic [CNT_W-1:0] hec_err_q;
    assign hec_ok        = hec_calc(buf_q[CW-1 -: 32]) == buf_q[CW-33 -: 8];
    assign hec_err_cnt_o = hec_err_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) hec_err_q <= '0;
        else if (state_q == CHECK && !hec_ok) hec_err_q <= hec_err_q + CNT_W'(~&hec_err_q);
    end
`else
    assign hec_ok        = 1'b1;
    assign hec_err_cnt_o = '0;
`endif

    assign push        = (state_q == CHECK) && hec_ok;
    assign rx_en_n_o   = rx_en_n_q;
    assign cell_port_o = PORT_W'(PORT_ID);
    assign cell_cnt_o  = cell_cnt_q;
    assign runt_cnt_o  = runt_q;

    // FIFO space is checked only when leaving IDLE: at most one cell is ever in flight
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            rx_en_n_q <= 1'b1;
            idx_q     <= '0;
            buf_q     <= '0;
            runt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    rx_en_n_q <= !(rx_clav_i && !fifo_full);
                    if (rx_clav_i && !fifo_full) state_q <= HUNT;
                end
                HUNT: if (rx_soc_i) begin
                    buf_q   <= {buf_q[CW-9:0], rx_data_i};
                    idx_q   <= 6'd1;
                    state_q <= RECV;
                end
                RECV: begin
                    buf_q <= {buf_q[CW-9:0], rx_data_i};
                    if (rx_soc_i) begin
                        idx_q  <= 6'd1;
                        runt_q <= runt_q + CNT_W'(~&runt_q);
                    end else if (idx_q == LAST) begin
                        rx_en_n_q <= 1'b1;
                        state_q   <= CHECK;
                    end else begin
                        idx_q <= idx_q + 6'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cell_cnt_q <= '0;
        else if (cell_valid_o && cell_ready_i) cell_cnt_q <= cell_cnt_q + CNT_W'(~&cell_cnt_q);
    end

    cell_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (uni_cell_t'(buf_q)),
        .ready_i (cell_ready_i),
        .valid_o (cell_valid_o),
        .data_o  (cell_data_o),
        .full_o  (fifo_full)
    );

endmodule

// File: tb/tb_utopia_rx_collector.sv
// tb_utopia_rx_collector: PHY byte-stream model, cell sink and stream-level reference parser.
module tb_utopia_rx_collector;
    import atm_cell_pkg::*;

    localparam int CW = 424;
`ifdef ATM_HEC_CHECK_EN
    localparam bit HEC_EN = 1'b1;
`else
    localparam bit HEC_EN = 1'b0;
`endif

    logic clk_i = 0, rst_ni = 0, rx_clav_i = 0, rx_soc_i = 0, cell_ready_i = 0;
    logic [7:0] rx_data_i = 0;
    logic rx_en_n_o, cell_valid_o;
    uni_cell_t cell_data_o;
    logic [1:0] cell_port_o;
    logic [6:0] cell_cnt_o, runt_cnt_o, hec_err_cnt_o;

    always #5 clk_i = ~clk_i;

    utopia_rx_collector #(.PORT_ID(2), .FIFO_DEPTH(2), .CNT_W(7)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .rx_clav_i(rx_clav_i), .rx_soc_i(rx_soc_i),
        .rx_data_i(rx_data_i), .rx_en_n_o(rx_en_n_o), .cell_valid_o(cell_valid_o),
        .cell_ready_i(cell_ready_i), .cell_data_o(cell_data_o), .cell_port_o(cell_port_o),
        .cell_cnt_o(cell_cnt_o), .runt_cnt_o(runt_cnt_o), .hec_err_cnt_o(hec_err_cnt_o)
    );

    int checks = 0, failures = 0, cyc = 0;
    int consumed = 0, last_cap = 0, rise_cyc = 0, ready_mode = 1;
    logic [8:0] phy_q[$], strm[$];
    logic [CW-1:0] got[$];
    logic en_prev = 1, shown = 0, v_prev = 0, x_prev = 0;
    logic [CW-1:0] d_prev;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chkc(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // HEC as polynomial long division of hdr*x^8 by x^8+x^2+x+1, plus coset
    function automatic logic [7:0] ref_hec(input logic [31:0] h);
        logic [39:0] r;
        r = {h, 8'h00};
        for (int i = 39; i >= 8; i--) if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
        return r[7:0] ^ 8'h55;
    endfunction

    // PHY: a presented byte leaves the queue once the DUT had rx_en_n low for that cycle
    initial begin
        forever begin
            @(negedge clk_i);
            if (!en_prev && shown && phy_q.size() > 0) begin
                void'(phy_q.pop_front());
                consumed++;
                last_cap = cyc;
            end
            shown = phy_q.size() > 0;
            {rx_soc_i, rx_data_i} = shown ? phy_q[0] : 9'h000;
            rx_clav_i = shown;
            en_prev = rx_en_n_o;
            cell_ready_i = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : ready_mode[0];
            if (rst_ni && v_prev && !x_prev) begin
                chk("hold_valid", int'(cell_valid_o), 1);
                chkc("hold_data", cell_data_o, d_prev);
            end
            if (cell_valid_o && !v_prev) rise_cyc = cyc;
            if (cell_valid_o && cell_ready_i) got.push_back(cell_data_o);
            v_prev = cell_valid_o && rst_ni;
            x_prev = cell_ready_i;
            d_prev = cell_data_o;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send(input logic [8:0] b);
        phy_q.push_back(b);
        strm.push_back(b);
    endtask

    task automatic make_cell(input logic [31:0] hdr, input logic [7:0] hx, output logic [CW-1:0] c);
        c[CW-1 -: 32] = hdr;
        c[CW-33 -: 8] = ref_hec(hdr) ^ hx;
        for (int i = 0; i < 48; i++) c[383-8*i -: 8] = 8'($urandom);
    endtask

    task automatic push_cell(input logic [CW-1:0] c, input int nbytes);
        for (int i = 0; i < nbytes; i++) send({1'(i == 0), c[CW-1-8*i -: 8]});
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while ((phy_q.size() != 0 || !rx_en_n_o) && n < maxc) begin
            @(negedge clk_i);
            n++;
        end
        chk("drain_timeout", int'(n >= maxc), 0);
        repeat (10) @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_ni = 0;
        repeat (2) @(negedge clk_i);
        phy_q.delete();
        strm.delete();
        got.delete();
        consumed = 0;
        rst_ni = 1;
        @(negedge clk_i);
    endtask

    typedef struct {
        logic [31:0] hdr;
        logic [7:0]  hx;
        logic [7:0]  vpi;
        logic [15:0] vci;
        logic [2:0]  pt;
        logic        clp;
    } vec_t;

    vec_t tbl[4];
    logic [CW-1:0] c, ca, cb, cc;
    logic [CW-1:0] exp_q[$];
    uni_cell_t g;
    logic [7:0] bytes[53];
    int len, er, eh, n, fwd;

    initial begin
        tbl[0] = '{32'h00100020, 8'h00, 8'h01, 16'h0002, 3'd0, 1'b0};
        tbl[1] = '{32'h00100020, 8'h01, 8'h01, 16'h0002, 3'd0, 1'b0};
        tbl[2] = '{32'hA5B6C7D8, 8'h00, 8'h5B, 16'h6C7D, 3'd4, 1'b0};
        tbl[3] = '{32'h12345679, 8'h00, 8'h23, 16'h4567, 3'd4, 1'b1};

        repeat (3) @(negedge clk_i);
        chk("rst_en_n", int'(rx_en_n_o), 1);
        chk("rst_valid", int'(cell_valid_o), 0);
        chkc("rst_data", cell_data_o, '0);
        chk("rst_cnts", int'({cell_cnt_o, runt_cnt_o, hec_err_cnt_o}), 0);
        rst_ni = 1;
        @(negedge clk_i);

        for (int r = 0; r < 4; r++) begin
            do_reset();
            ready_mode = 1;
            make_cell(tbl[r].hdr, tbl[r].hx, c);
            push_cell(c, 53);
            drain(300);
            fwd = (HEC_EN && tbl[r].hx != 0) ? 0 : 1;
            chk("tbl_fwd", got.size(), fwd);
            chk("tbl_cell_cnt", int'(cell_cnt_o), fwd);
            chk("tbl_hec_cnt", int'(hec_err_cnt_o), 1 - fwd);
            if (got.size() > 0) begin
                g = uni_cell_t'(got[0]);
                chk("tbl_vpi", int'(g.vpi), int'(tbl[r].vpi));
                chk("tbl_vci", int'(g.vci), int'(tbl[r].vci));
                chk("tbl_pt_clp", int'({g.pt, g.clp}), int'({tbl[r].pt, tbl[r].clp}));
                chkc("tbl_cell", got[0], c);
            end
            if (r == 0) begin
                chk("latency", rise_cyc - last_cap, 2);
                chk("port", int'(cell_port_o), 2);
            end
        end

        do_reset();
        ready_mode = 0;
        make_cell(32'h01000010, 8'h00, ca);
        make_cell(32'h02000020, 8'h00, cb);
        make_cell(32'h03000030, 8'h00, cc);
        push_cell(ca, 53);
        push_cell(cb, 53);
        push_cell(cc, 53);
        repeat (200) @(negedge clk_i);
        chk("bp_en_n", int'(rx_en_n_o), 1);
        chk("bp_left", phy_q.size(), 53);
        chk("bp_valid", int'(cell_valid_o), 1);
        chkc("bp_head", cell_data_o, ca);
        ready_mode = 1;
        drain(400);
        chk("bp_count", got.size(), 3);
        if (got.size() == 3) begin
            chkc("bp_order0", got[0], ca);
            chkc("bp_order1", got[1], cb);
            chkc("bp_order2", got[2], cc);
        end

        do_reset();
        make_cell(32'h0AB00CD0, 8'h00, ca);
        make_cell(32'h0BC00DE0, 8'h00, cb);
        push_cell(ca, 20);
        push_cell(cb, 53);
        drain(300);
        chk("runt_cnt", int'(runt_cnt_o), 1);
        chk("runt_out", got.size(), 1);
        if (got.size() == 1) chkc("runt_cell", got[0], cb);

        do_reset();
        ready_mode = 0;
        make_cell(32'h0CD00EF0, 8'h00, ca);
        make_cell(32'h0DE00F00, 8'h00, cb);
        push_cell(ca, 53);
        push_cell(cb, 53);
        n = 0;
        while (consumed < 83 && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        chk("mid_timeout", int'(n >= 500), 0);
        chk("mid_valid_pre", int'(cell_valid_o), 1);
        rst_ni = 0;
        #1;
        chk("mid_en_n", int'(rx_en_n_o), 1);
        chk("mid_valid", int'(cell_valid_o), 0);
        chkc("mid_data", cell_data_o, '0);
        repeat (2) @(negedge clk_i);
        phy_q.delete();
        got.delete();
        rst_ni = 1;
        ready_mode = 1;
        make_cell(32'h0EF01230, 8'h00, cc);
        push_cell(cc, 53);
        drain(300);
        chk("mid_out", got.size(), 1);
        if (got.size() == 1) chkc("mid_cell", got[0], cc);
        chk("mid_cnts", int'({cell_cnt_o, runt_cnt_o, hec_err_cnt_o}), int'({7'd1, 7'd0, 7'd0}));

        do_reset();
        exp_q.delete();
        for (int i = 0; i < 130; i++) begin
            make_cell($urandom, 8'h00, c);
            push_cell(c, 53);
            exp_q.push_back(c);
            if (i == 99) begin
                drain(100 * 80);
                chk("b2b_count", got.size(), 100);
                chk("b2b_cell_cnt", int'(cell_cnt_o), 100);
            end
        end
        drain(30 * 80);
        chk("sat_cell_cnt", int'(cell_cnt_o), 127);
        chk("sat_count", got.size(), 130);
        n = 0;
        for (int i = 0; i < got.size() && i < 130; i++) if (got[i] !== exp_q[i]) n++;
        chk("b2b_bad_cells", n, 0);

        do_reset();
        ready_mode = 2;
        for (int s = 0; s < 30; s++) begin
            n = $urandom_range(0, 9);
            if (n < 2) begin
                repeat ($urandom_range(1, 5)) send({1'b0, 8'($urandom)});
            end else if (n < 4) begin
                send({1'b1, 8'($urandom)});
                repeat ($urandom_range(1, 45)) send({1'b0, 8'($urandom)});
            end else begin
                make_cell($urandom, (n == 4) ? 8'($urandom_range(1, 255)) : 8'h00, c);
                push_cell(c, 53);
            end
        end
        make_cell($urandom, 8'h00, c);
        push_cell(c, 53);
        exp_q.delete();
        len = 0;
        er = 0;
        eh = 0;
        foreach (strm[k]) begin
            if (strm[k][8]) begin
                if (len > 0) er++;
                bytes[0] = strm[k][7:0];
                len = 1;
            end else if (len > 0) begin
                bytes[len] = strm[k][7:0];
                len++;
            end
            if (len == 53) begin
                len = 0;
                if (HEC_EN && ref_hec({bytes[0], bytes[1], bytes[2], bytes[3]}) != bytes[4]) eh++;
                else begin
                    for (int i = 0; i < 53; i++) c[CW-1-8*i -: 8] = bytes[i];
                    exp_q.push_back(c);
                end
            end
        end
        drain(20000);
        ready_mode = 1;
        repeat (10) @(negedge clk_i);
        chk("rnd_count", got.size(), exp_q.size());
        chk("rnd_cell_cnt", int'(cell_cnt_o), exp_q.size());
        chk("rnd_runt_cnt", int'(runt_cnt_o), er);
        chk("rnd_hec_cnt", int'(hec_err_cnt_o), eh);
        n = 0;
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) if (got[i] !== exp_q[i]) n++;
        chk("rnd_bad_cells", n, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
